// File: rtl/block_error_counter.sv
// block_error_counter
//
// Compares each transmitted 66-bit coded block against the same block after
// the channel and keeps link statistics. The statistics are block, errored
// block, payload bit error and sync-header error counts, the number of error
// bursts, and the longest burst seen. A block is qualified for statistics by
// the selected mode: aligners only, control blocks, data blocks, or everything.
// Sync-header mismatches are counted for every valid enabled block, whatever
// the mode.
//
// The design is a two-stage pipeline. Stage 1 registers the payload error
// vector and the qualification. Stage 2 counts the error bits and updates all
// statistics. Results appear on the second rising edge after the input cycle.
//
// Ports:
//   i_clock          clock
//   i_reset          synchronous active-high reset
//   i_valid          ref/rx data and aligner tag are valid this cycle
//   i_aligner_tag    current block is an aligner
//   i_ref_data       transmitted block (sync header in [65:64])
//   i_rx_data        received block
//   i_rf_mode        qualification mode: 0 ALIN, 1 CTRL, 2 DATA, 3 ALL
//   i_rf_enable      checking enable
//   i_rf_clear       one-cycle pulse that zeroes all statistics
//   o_blk_cnt        qualified blocks checked
//   o_blk_err_cnt    qualified blocks with at least one payload bit error
//   o_bit_err_cnt    total payload bit errors
//   o_sh_err_cnt     sync-header mismatches
//   o_burst_cnt      error bursts started
//   o_max_burst_len  longest burst in blocks (includes a burst still open)
//   o_err_flag       one-cycle pulse per errored qualified block
module block_error_counter #(
  parameter int NB_CODED_BLOCK = 66,
  parameter int NB_CNT         = 32,
  parameter int NB_BURST_LEN   = 16,
  parameter int N_MODES        = 4,
  localparam int NB_MODES      = $clog2(N_MODES)
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_valid,
  input  logic                      i_aligner_tag,
  input  logic [NB_CODED_BLOCK-1:0] i_ref_data,
  input  logic [NB_CODED_BLOCK-1:0] i_rx_data,
  input  logic [NB_MODES-1:0]       i_rf_mode,
  input  logic                      i_rf_enable,
  input  logic                      i_rf_clear,
  output logic [NB_CNT-1:0]         o_blk_cnt,
  output logic [NB_CNT-1:0]         o_blk_err_cnt,
  output logic [NB_CNT-1:0]         o_bit_err_cnt,
  output logic [NB_CNT-1:0]         o_sh_err_cnt,
  output logic [NB_CNT-1:0]         o_burst_cnt,
  output logic [NB_BURST_LEN-1:0]   o_max_burst_len,
  output logic                      o_err_flag
);

  localparam int NB_PAYLOAD = NB_CODED_BLOCK - 2;
  localparam int NB_POP     = $clog2(NB_PAYLOAD + 1);
  localparam int NB_SUM     = NB_CNT + 1;

  localparam logic [NB_MODES-1:0] MODE_ALIN = NB_MODES'(0);
  localparam logic [NB_MODES-1:0] MODE_CTRL = NB_MODES'(1);
  localparam logic [NB_MODES-1:0] MODE_DATA = NB_MODES'(2);
  localparam logic [NB_MODES-1:0] MODE_ALL  = NB_MODES'(3);

  localparam logic [1:0] SH_CTRL = 2'b10;
  localparam logic [1:0] SH_DATA = 2'b01;

  typedef enum logic {
    IDLE,
    IN_BURST
  } burst_state_t;

  // Incrementing a statistics counter stops at all-ones.
  function automatic logic [NB_CNT-1:0] sat_inc(input logic [NB_CNT-1:0] value);
    if (&value) begin
      return value;
    end
    return value + NB_CNT'(1);
  endfunction

  function automatic logic [NB_POP-1:0] popcount(input logic [NB_PAYLOAD-1:0] vec);
    logic [NB_POP-1:0] count;
    count = '0;
    for (int i = 0; i < NB_PAYLOAD; i++) begin
      count = count + NB_POP'(vec[i]);
    end
    return count;
  endfunction

  logic [1:0]            ref_sh;
  logic [1:0]            rx_sh;
  logic [NB_PAYLOAD-1:0] ref_payload;
  logic [NB_PAYLOAD-1:0] rx_payload;
  logic                  mode_match;
  logic                  in_qualified;
  logic                  in_sh_mismatch;

  logic [NB_PAYLOAD-1:0] s1_err_vec;
  logic                  s1_qualified;
  logic                  s1_sh_mismatch;

  logic [NB_POP-1:0]     pop_count;
  logic                  blk_errored;
  logic [NB_SUM-1:0]     bit_sum;
  logic [NB_CNT-1:0]     bit_err_next;

  burst_state_t          state;
  burst_state_t          next_state;
  logic [NB_BURST_LEN-1:0] cur_len;
  logic [NB_BURST_LEN-1:0] next_len;
  logic                  burst_start;

  assign ref_sh      = i_ref_data[NB_CODED_BLOCK-1 -: 2];
  assign rx_sh       = i_rx_data[NB_CODED_BLOCK-1 -: 2];
  assign ref_payload = i_ref_data[NB_PAYLOAD-1:0];
  assign rx_payload  = i_rx_data[NB_PAYLOAD-1:0];

  // Block type comes from the transmitted header only, so corruption of the
  // received header cannot move a block between the CTRL and DATA classes.
  always_comb begin
    mode_match = 1'b0;
    case (i_rf_mode)
      MODE_ALIN: mode_match = i_aligner_tag;
      MODE_CTRL: mode_match = (ref_sh == SH_CTRL);
      MODE_DATA: mode_match = (ref_sh == SH_DATA);
      MODE_ALL:  mode_match = 1'b1;
      default:   mode_match = 1'b0;
    endcase
  end

  assign in_qualified   = i_valid && i_rf_enable && mode_match;
  assign in_sh_mismatch = i_valid && i_rf_enable && (ref_sh != rx_sh);

  // Stage 1: the mode and enable are sampled here, so a block keeps the
  // qualification it entered with even if the mode changes while it is in flight.
  always_ff @(posedge i_clock) begin
    if (i_reset || i_rf_clear) begin
      s1_err_vec     <= '0;
      s1_qualified   <= 1'b0;
      s1_sh_mismatch <= 1'b0;
    end else begin
      s1_err_vec     <= ref_payload ^ rx_payload;
      s1_qualified   <= in_qualified;
      s1_sh_mismatch <= in_sh_mismatch;
    end
  end

  assign pop_count   = popcount(s1_err_vec);
  assign blk_errored = s1_qualified && (pop_count != '0);

  // One extra bit catches overflow of the accumulated bit count.
  assign bit_sum      = {1'b0, o_bit_err_cnt} + NB_SUM'(pop_count);
  assign bit_err_next = bit_sum[NB_CNT] ? '1 : bit_sum[NB_CNT-1:0];

  always_ff @(posedge i_clock) begin
    if (i_reset || i_rf_clear) begin
      state   <= IDLE;
      cur_len <= '0;
    end else begin
      state   <= next_state;
      cur_len <= next_len;
    end
  end

  // Only qualified blocks move the burst FSM. Idle cycles and blocks filtered
  // out by the mode do not end a burst.
  always_comb begin
    next_state  = state;
    next_len    = cur_len;
    burst_start = 1'b0;
    if (s1_qualified) begin
      case (state)
        IDLE: begin
          if (blk_errored) begin
            next_state  = IN_BURST;
            next_len    = NB_BURST_LEN'(1);
            burst_start = 1'b1;
          end
        end
        IN_BURST: begin
          if (blk_errored) begin
            next_len = (&cur_len) ? cur_len : cur_len + NB_BURST_LEN'(1);
          end else begin
            next_state = IDLE;
            next_len   = '0;
          end
        end
      endcase
    end
  end

  // Stage 2 statistics. A clear discards the block in stage 1 because
  // the clear takes priority over every update here.
  always_ff @(posedge i_clock) begin
    if (i_reset || i_rf_clear) begin
      o_blk_cnt       <= '0;
      o_blk_err_cnt   <= '0;
      o_bit_err_cnt   <= '0;
      o_sh_err_cnt    <= '0;
      o_burst_cnt     <= '0;
      o_max_burst_len <= '0;
      o_err_flag      <= 1'b0;
    end else begin
      o_err_flag <= blk_errored;
      if (s1_qualified) begin
        o_blk_cnt     <= sat_inc(o_blk_cnt);
        o_bit_err_cnt <= bit_err_next;
      end
      if (blk_errored) begin
        o_blk_err_cnt <= sat_inc(o_blk_err_cnt);
        if (next_len > o_max_burst_len) begin
          o_max_burst_len <= next_len;
        end
      end
      if (burst_start) begin
        o_burst_cnt <= sat_inc(o_burst_cnt);
      end
      if (s1_sh_mismatch) begin
        o_sh_err_cnt <= sat_inc(o_sh_err_cnt);
      end
    end
  end

endmodule

// File: tb/tb_block_error_counter.sv
// tb_block_error_counter
//
// Self-checking bench for block_error_counter built with 8-bit counters, so
// that saturation is reachable. Expected values come from a block-level
// reference model. The model tracks each block as a record (qualified, error
// bit count, header mismatch) and retires it one edge after it is accepted.
// Directed tables and sequences also compare against hand-derived constants.
//
// Ports: none (top-level bench).
module tb_block_error_counter;

  localparam int CNT_MAX   = 255;
  localparam int BURST_MAX = 65535;

  localparam logic [1:0] MODE_ALIN = 2'd0;
  localparam logic [1:0] MODE_CTRL = 2'd1;
  localparam logic [1:0] MODE_DATA = 2'd2;
  localparam logic [1:0] MODE_ALL  = 2'd3;

  localparam logic [63:0] PAY   = 64'h0123_4567_89AB_CDEF;
  localparam logic [65:0] DBLK  = {2'b01, PAY};
  localparam logic [65:0] CBLK  = {2'b10, PAY};
  localparam logic [65:0] E1    = 66'h1;
  localparam logic [65:0] E2    = 66'h3;
  localparam logic [65:0] E8    = 66'hFF;
  localparam logic [65:0] E58   = {2'b00, 64'h03FF_FFFF_FFFF_FFFF};
  localparam logic [65:0] EFULL = {2'b00, {64{1'b1}}};

  typedef struct {
    logic        rst;
    logic        clr;
    logic        vld;
    logic        tag;
    logic [1:0]  mode;
    logic        en;
    logic [65:0] refd;
    logic [65:0] rxd;
  } stim_t;

  typedef struct {
    stim_t st;
    int    blk;
    int    berr;
    int    bits;
    int    sh;
    int    burst;
    int    maxb;
    int    flag;
  } vec_t;

  logic        i_clock;
  logic        i_reset;
  logic        i_valid;
  logic        i_aligner_tag;
  logic [65:0] i_ref_data;
  logic [65:0] i_rx_data;
  logic [1:0]  i_rf_mode;
  logic        i_rf_enable;
  logic        i_rf_clear;
  logic [7:0]  o_blk_cnt;
  logic [7:0]  o_blk_err_cnt;
  logic [7:0]  o_bit_err_cnt;
  logic [7:0]  o_sh_err_cnt;
  logic [7:0]  o_burst_cnt;
  logic [15:0] o_max_burst_len;
  logic        o_err_flag;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_blk, m_berr, m_bits, m_sh, m_burst, m_maxb, m_flag;
  int m_in_burst, m_cur_len;
  int p_qual, p_pop, p_sh;

  block_error_counter #(
    .NB_CNT(8)
  ) dut (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_valid        (i_valid),
    .i_aligner_tag  (i_aligner_tag),
    .i_ref_data     (i_ref_data),
    .i_rx_data      (i_rx_data),
    .i_rf_mode      (i_rf_mode),
    .i_rf_enable    (i_rf_enable),
    .i_rf_clear     (i_rf_clear),
    .o_blk_cnt      (o_blk_cnt),
    .o_blk_err_cnt  (o_blk_err_cnt),
    .o_bit_err_cnt  (o_bit_err_cnt),
    .o_sh_err_cnt   (o_sh_err_cnt),
    .o_burst_cnt    (o_burst_cnt),
    .o_max_burst_len(o_max_burst_len),
    .o_err_flag     (o_err_flag)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  function automatic int sat(input int v, input int max);
    return (v > max) ? max : v;
  endfunction

  function automatic stim_t mkStim(input logic rst, input logic clr, input logic vld,
                                   input logic tag, input logic [1:0] mode, input logic en,
                                   input logic [65:0] refd, input logic [65:0] rxd);
    stim_t s;
    s.rst = rst; s.clr = clr; s.vld = vld; s.tag = tag;
    s.mode = mode; s.en = en; s.refd = refd; s.rxd = rxd;
    return s;
  endfunction

  function automatic vec_t mkVec(input logic vld, input logic en, input logic [1:0] mode,
                                 input logic [65:0] refd, input logic [65:0] rxd,
                                 input int blk, input int berr, input int bits, input int sh,
                                 input int burst, input int maxb, input int flag);
    vec_t v;
    v.st = mkStim(1'b0, 1'b0, vld, 1'b0, mode, en, refd, rxd);
    v.blk = blk; v.berr = berr; v.bits = bits; v.sh = sh;
    v.burst = burst; v.maxb = maxb; v.flag = flag;
    return v;
  endfunction

  function automatic int modeOk(input stim_t s);
    case (s.mode)
      MODE_ALIN: return int'(s.tag);
      MODE_CTRL: return (s.refd[65:64] == 2'b10) ? 1 : 0;
      MODE_DATA: return (s.refd[65:64] == 2'b01) ? 1 : 0;
      default:   return 1;
    endcase
  endfunction

  // One clock edge of the block-level model. The block accepted on the previous
  // edge is retired into the statistics; the current input becomes the new one.
  task automatic modelEdge(input stim_t s);
    if (s.rst || s.clr) begin
      m_blk = 0; m_berr = 0; m_bits = 0; m_sh = 0; m_burst = 0; m_maxb = 0; m_flag = 0;
      m_in_burst = 0; m_cur_len = 0;
      p_qual = 0; p_pop = 0; p_sh = 0;
      return;
    end
    m_flag = 0;
    if (p_sh != 0) m_sh = sat(m_sh + 1, CNT_MAX);
    if (p_qual != 0) begin
      m_blk  = sat(m_blk + 1, CNT_MAX);
      m_bits = sat(m_bits + p_pop, CNT_MAX);
      if (p_pop > 0) begin
        m_berr = sat(m_berr + 1, CNT_MAX);
        m_flag = 1;
        if (m_in_burst == 0) begin
          m_in_burst = 1;
          m_cur_len  = 1;
          m_burst    = sat(m_burst + 1, CNT_MAX);
        end else begin
          m_cur_len = sat(m_cur_len + 1, BURST_MAX);
        end
        if (m_cur_len > m_maxb) m_maxb = m_cur_len;
      end else begin
        m_in_burst = 0;
      end
    end
    p_qual = (s.vld && s.en && (modeOk(s) != 0)) ? 1 : 0;
    p_sh   = (s.vld && s.en && (s.refd[65:64] != s.rxd[65:64])) ? 1 : 0;
    p_pop  = $countones(s.refd[63:0] ^ s.rxd[63:0]);
  endtask

  task automatic applyStimulus(input stim_t s);
    i_reset       = s.rst;
    i_rf_clear    = s.clr;
    i_valid       = s.vld;
    i_aligner_tag = s.tag;
    i_rf_mode     = s.mode;
    i_rf_enable   = s.en;
    i_ref_data    = s.refd;
    i_rx_data     = s.rxd;
    @(posedge i_clock);
    modelEdge(s);
    @(negedge i_clock);
  endtask

  task automatic checkValue(input string name, input logic [31:0] actual,
                            input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input string name);
    checkValue({name, ".blk_cnt"},       32'(o_blk_cnt),       m_blk);
    checkValue({name, ".blk_err_cnt"},   32'(o_blk_err_cnt),   m_berr);
    checkValue({name, ".bit_err_cnt"},   32'(o_bit_err_cnt),   m_bits);
    checkValue({name, ".sh_err_cnt"},    32'(o_sh_err_cnt),    m_sh);
    checkValue({name, ".burst_cnt"},     32'(o_burst_cnt),     m_burst);
    checkValue({name, ".max_burst_len"}, 32'(o_max_burst_len), m_maxb);
    checkValue({name, ".err_flag"},      32'(o_err_flag),      m_flag);
  endtask

  task automatic doReset();
    applyStimulus(mkStim(1'b1, 1'b0, 1'b0, 1'b0, MODE_ALL, 1'b1, DBLK, DBLK));
    applyStimulus(mkStim(1'b1, 1'b0, 1'b1, 1'b0, MODE_ALL, 1'b1, DBLK, DBLK ^ E8));
    checkOutput("reset");
  endtask

  task automatic sendBlock(input string name, input logic [1:0] mode, input logic tag,
                           input logic [65:0] refd, input logic [65:0] rxd, input logic clr);
    applyStimulus(mkStim(1'b0, clr, 1'b1, tag, mode, 1'b1, refd, rxd));
    checkOutput(name);
  endtask

  task automatic idleCycles(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(mkStim(1'b0, 1'b0, 1'b0, 1'b0, MODE_ALL, 1'b1, DBLK, DBLK));
      checkOutput(name);
    end
  endtask

  task automatic checkAllZero(input string name);
    checkValue({name, ".blk_cnt"},       32'(o_blk_cnt),       0);
    checkValue({name, ".blk_err_cnt"},   32'(o_blk_err_cnt),   0);
    checkValue({name, ".bit_err_cnt"},   32'(o_bit_err_cnt),   0);
    checkValue({name, ".sh_err_cnt"},    32'(o_sh_err_cnt),    0);
    checkValue({name, ".burst_cnt"},     32'(o_burst_cnt),     0);
    checkValue({name, ".max_burst_len"}, 32'(o_max_burst_len), 0);
    checkValue({name, ".err_flag"},      32'(o_err_flag),      0);
  endtask

  initial begin
    vec_t        vecs [19];
    stim_t       s;
    logic [63:0] one;
    logic [63:0] mask;
    logic [1:0]  sh;

    i_reset = 1'b0; i_rf_clear = 1'b0; i_valid = 1'b0; i_aligner_tag = 1'b0;
    i_rf_mode = MODE_ALL; i_rf_enable = 1'b0; i_ref_data = '0; i_rx_data = '0;
    one = 64'd1;

    // Outputs after each row's edge reflect the block of the previous row.
    for (int k = 0; k < 10; k++) begin
      vecs[k] = mkVec(1'b1, 1'b1, MODE_ALL, DBLK, DBLK, k, 0, 0, 0, 0, 0, 0);
    end
    vecs[10] = mkVec(1'b1, 1'b1, MODE_ALL,  DBLK, DBLK ^ E8,            10, 0, 0, 0, 0, 0, 0);
    vecs[11] = mkVec(1'b0, 1'b1, MODE_ALL,  DBLK, DBLK,                 11, 1, 8, 0, 1, 1, 1);
    vecs[12] = mkVec(1'b0, 1'b1, MODE_ALL,  DBLK, DBLK,                 11, 1, 8, 0, 1, 1, 0);
    vecs[13] = mkVec(1'b1, 1'b1, MODE_ALL,  DBLK, DBLK,                 11, 1, 8, 0, 1, 1, 0);
    vecs[14] = mkVec(1'b0, 1'b1, MODE_ALL,  DBLK, DBLK,                 12, 1, 8, 0, 1, 1, 0);
    vecs[15] = mkVec(1'b1, 1'b0, MODE_ALL,  DBLK, {2'b10, PAY ^ one},   12, 1, 8, 0, 1, 1, 0);
    vecs[16] = mkVec(1'b0, 1'b1, MODE_ALL,  DBLK, DBLK,                 12, 1, 8, 0, 1, 1, 0);
    vecs[17] = mkVec(1'b1, 1'b1, MODE_DATA, DBLK, {2'b00, PAY},         12, 1, 8, 0, 1, 1, 0);
    vecs[18] = mkVec(1'b0, 1'b1, MODE_ALL,  DBLK, DBLK,                 13, 1, 8, 1, 1, 1, 0);

    doReset();
    checkAllZero("reset_const");

    for (int k = 0; k < 19; k++) begin
      applyStimulus(vecs[k].st);
      checkOutput($sformatf("vec%0d", k));
      checkValue($sformatf("vec%0d.tbl_blk", k),   32'(o_blk_cnt),       vecs[k].blk);
      checkValue($sformatf("vec%0d.tbl_berr", k),  32'(o_blk_err_cnt),   vecs[k].berr);
      checkValue($sformatf("vec%0d.tbl_bits", k),  32'(o_bit_err_cnt),   vecs[k].bits);
      checkValue($sformatf("vec%0d.tbl_sh", k),    32'(o_sh_err_cnt),    vecs[k].sh);
      checkValue($sformatf("vec%0d.tbl_burst", k), 32'(o_burst_cnt),     vecs[k].burst);
      checkValue($sformatf("vec%0d.tbl_maxb", k),  32'(o_max_burst_len), vecs[k].maxb);
      checkValue($sformatf("vec%0d.tbl_flag", k),  32'(o_err_flag),      vecs[k].flag);
    end

    // Two bursts of 3 and 5 errored blocks separated by clean blocks.
    doReset();
    for (int i = 0; i < 3; i++) sendBlock("burst", MODE_ALL, 1'b0, DBLK, DBLK ^ E1, 1'b0);
    sendBlock("burst", MODE_ALL, 1'b0, DBLK, DBLK, 1'b0);
    for (int i = 0; i < 5; i++) sendBlock("burst", MODE_ALL, 1'b0, DBLK, DBLK ^ E1, 1'b0);
    sendBlock("burst", MODE_ALL, 1'b0, DBLK, DBLK, 1'b0);
    idleCycles("burst", 2);
    checkValue("burst.final_burst_cnt", 32'(o_burst_cnt),     2);
    checkValue("burst.final_max_len",   32'(o_max_burst_len), 5);
    checkValue("burst.final_blk_err",   32'(o_blk_err_cnt),   8);
    checkValue("burst.final_blk",       32'(o_blk_cnt),       10);

    // CTRL mode: interleaved errored data blocks are filtered out and do not end the burst.
    doReset();
    for (int i = 0; i < 4; i++) begin
      sendBlock("ctrl", MODE_CTRL, 1'b0, CBLK, CBLK ^ E2, 1'b0);
      sendBlock("ctrl", MODE_CTRL, 1'b0, DBLK, DBLK ^ E2, 1'b0);
    end
    idleCycles("ctrl", 2);
    checkValue("ctrl.final_blk",       32'(o_blk_cnt),       4);
    checkValue("ctrl.final_blk_err",   32'(o_blk_err_cnt),   4);
    checkValue("ctrl.final_burst_cnt", 32'(o_burst_cnt),     1);
    checkValue("ctrl.final_max_len",   32'(o_max_burst_len), 4);
    checkValue("ctrl.final_bits",      32'(o_bit_err_cnt),   8);

    // Header mismatch is counted even though the block does not qualify.
    doReset();
    sendBlock("shmis", MODE_ALIN, 1'b0, DBLK, {2'b11, PAY}, 1'b0);
    idleCycles("shmis", 2);
    checkValue("shmis.final_sh",   32'(o_sh_err_cnt),  1);
    checkValue("shmis.final_blk",  32'(o_blk_cnt),     0);
    checkValue("shmis.final_bits", 32'(o_bit_err_cnt), 0);

    // Bit error counter driven to 250, then past the 8-bit limit.
    doReset();
    for (int i = 0; i < 3; i++) sendBlock("satur", MODE_ALL, 1'b0, DBLK, DBLK ^ EFULL, 1'b0);
    sendBlock("satur", MODE_ALL, 1'b0, DBLK, DBLK ^ E58, 1'b0);
    idleCycles("satur", 2);
    checkValue("satur.bits_250", 32'(o_bit_err_cnt), 250);
    sendBlock("satur", MODE_ALL, 1'b0, DBLK, DBLK ^ EFULL, 1'b0);
    idleCycles("satur", 2);
    checkValue("satur.bits_255", 32'(o_bit_err_cnt), 255);
    sendBlock("satur", MODE_ALL, 1'b0, DBLK, DBLK ^ EFULL, 1'b0);
    idleCycles("satur", 2);
    checkValue("satur.bits_held", 32'(o_bit_err_cnt), 255);
    checkValue("satur.blk",       32'(o_blk_cnt),     6);

    // Clear arrives with an errored block in stage 1 and another at the input.
    doReset();
    sendBlock("clear", MODE_ALL, 1'b0, DBLK, DBLK ^ E8, 1'b0);
    sendBlock("clear", MODE_ALL, 1'b0, DBLK, DBLK ^ E8, 1'b0);
    sendBlock("clear", MODE_ALL, 1'b0, DBLK, {2'b10, PAY ^ 64'hF0}, 1'b1);
    idleCycles("clear", 2);
    checkAllZero("clear_const");

    // Reset in the middle of a burst discards it.
    doReset();
    sendBlock("rstmid", MODE_ALL, 1'b0, DBLK, DBLK ^ E1, 1'b0);
    sendBlock("rstmid", MODE_ALL, 1'b0, DBLK, DBLK ^ E1, 1'b0);
    applyStimulus(mkStim(1'b1, 1'b1, 1'b1, 1'b0, MODE_ALL, 1'b1, DBLK, DBLK ^ E1));
    checkOutput("rstmid");
    sendBlock("rstmid", MODE_ALL, 1'b0, DBLK, DBLK ^ E1, 1'b0);
    idleCycles("rstmid", 2);
    checkValue("rstmid.burst_cnt", 32'(o_burst_cnt),     1);
    checkValue("rstmid.max_len",   32'(o_max_burst_len), 1);
    checkValue("rstmid.blk",       32'(o_blk_cnt),       1);

    // Randomized traffic against the model, including mode/enable changes,
    // clears and resets at arbitrary points.
    doReset();
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0, 1:    mask = '0;
        2:       mask = one << $urandom_range(0, 63);
        default: mask = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      endcase
      sh = 2'($urandom_range(0, 3));
      s.rst  = ($urandom_range(0, 63) == 0);
      s.clr  = ($urandom_range(0, 31) == 0);
      s.vld  = ($urandom_range(0, 3) != 0);
      s.tag  = 1'($urandom_range(0, 1));
      s.mode = 2'($urandom_range(0, 3));
      s.en   = ($urandom_range(0, 7) != 0);
      s.refd = {sh, {$urandom, $urandom}};
      s.rxd  = s.refd ^ {(($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00), mask};
      applyStimulus(s);
      checkOutput("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
